// File: rtl/arithmetic_encoder.sv
// Multi-symbol range coder core: q15 interval update plus range/low normalization.
// Two cycles per symbol (capture, then update); no handshake, producer aligns to phase 0.
module arithmetic_encoder #(
    parameter int GENERAL_RANGE_WIDTH    = 16,
    parameter int GENERAL_LOW_WIDTH      = 24,
    parameter int GENERAL_SYMBOL_WIDTH   = 4,
    parameter int GENERAL_LUT_ADDR_WIDTH = 8,
    parameter int GENERAL_LUT_DATA_WIDTH = 16,
    parameter int GENERAL_D_SIZE         = 4
) (
    input  logic                              general_clk,
    input  logic                              reset,
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fl,
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fh,
    input  logic [GENERAL_SYMBOL_WIDTH-1:0]   general_symbol,
    input  logic [GENERAL_SYMBOL_WIDTH:0]     general_nsyms,
    output logic [GENERAL_RANGE_WIDTH-1:0]    RANGE_OUTPUT,
    output logic [GENERAL_LOW_WIDTH-1:0]      LOW_OUTPUT
);

    localparam int RW = GENERAL_RANGE_WIDTH;
    localparam int LW = GENERAL_LOW_WIDTH;
    localparam int SW = GENERAL_SYMBOL_WIDTH;
    localparam int LA = GENERAL_LUT_ADDR_WIDTH;
    localparam int LD = GENERAL_LUT_DATA_WIDTH;
    localparam int DW = GENERAL_D_SIZE;

    logic          r_phase;
    logic [RW-1:0] r_fl;
    logic [RW-1:0] r_fh;
    logic [SW-1:0] r_sym;
    logic [SW:0]   r_nsyms;
    logic [RW-1:0] r_range;
    logic [LW-1:0] r_low;

    logic [31:0]   w_r;
    logic [31:0]   w_n_minus_s;
    logic [31:0]   w_v;
    logic [31:0]   w_u;
    logic [31:0]   w_lp;
    logic [RW-1:0] w_rn;
    logic [DW-1:0] w_d;
    logic [RW-1:0] w_range_nxt;
    logic [LW-1:0] w_low_nxt;

    // Leading-zero count of one byte; the full count is built from two lookups.
    function automatic logic [LD-1:0] f_lzc_rom(input logic [LA-1:0] a);
        f_lzc_rom = LD'(LA);
        for (int i = 0; i < LA; i++) begin
            if (a[i]) f_lzc_rom = LD'(LA - 1 - i);
        end
    endfunction

    always_comb begin
        w_r         = 32'(r_range);
        w_n_minus_s = 32'(r_nsyms) - 32'd1 - 32'(r_sym);
        w_v         = (((w_r >> 8) * (32'(r_fh) >> 6)) >> 1) + (w_n_minus_s << 2);
        w_u         = (((w_r >> 8) * (32'(r_fl) >> 6)) >> 1) + ((w_n_minus_s + 32'd1) << 2);
        // fl carries bit 15 only for the first symbol (fl = 32768).
        if (!r_fl[RW-1]) begin
            w_lp = 32'(r_low) + (w_r - w_u);
            w_rn = RW'(w_u - w_v);
        end else begin
            w_lp = 32'(r_low);
            w_rn = RW'(w_r - w_v);
        end
        if (w_rn[RW-1 -: LA] != '0) begin
            w_d = DW'(f_lzc_rom(w_rn[RW-1 -: LA]));
        end else begin
            w_d = DW'(32'(LA) + 32'(f_lzc_rom(w_rn[LA-1:0])));
        end
        w_range_nxt = w_rn << w_d;
        w_low_nxt   = LW'(w_lp << w_d);
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_fl    <= '0;
            r_fh    <= '0;
            r_sym   <= '0;
            r_nsyms <= '0;
            r_range <= RW'(1) << (RW - 1);
            r_low   <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_fl    <= general_fl;
                r_fh    <= general_fh;
                r_sym   <= general_symbol;
                r_nsyms <= general_nsyms;
            end else begin
                r_range <= w_range_nxt;
                r_low   <= w_low_nxt;
            end
        end
    end

    assign RANGE_OUTPUT = r_range;
    assign LOW_OUTPUT   = r_low;

endmodule

// File: tb/tb_arithmetic_encoder.sv
// Scoreboarded bench for arithmetic_encoder against a software q15 range-coder model.
module tb_arithmetic_encoder;

    logic        general_clk;
    logic        reset;
    logic [15:0] general_fl;
    logic [15:0] general_fh;
    logic [3:0]  general_symbol;
    logic [4:0]  general_nsyms;
    logic [15:0] RANGE_OUTPUT;
    logic [23:0] LOW_OUTPUT;

    typedef struct packed {
        logic [15:0] rng;
        logic [23:0] low;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned m_rng;
    int unsigned m_low;

    arithmetic_encoder dut (
        .general_clk    (general_clk),
        .reset          (reset),
        .general_fl     (general_fl),
        .general_fh     (general_fh),
        .general_symbol (general_symbol),
        .general_nsyms  (general_nsyms),
        .RANGE_OUTPUT   (RANGE_OUTPUT),
        .LOW_OUTPUT     (LOW_OUTPUT)
    );

    initial begin
        general_clk = 1'b0;
        forever #6 general_clk = ~general_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: od_ec_encode_q15 followed by bit-at-a-time renormalization.
    task automatic model_step(input int unsigned fl, input int unsigned fh, input int unsigned s,
                              input int unsigned ns, input int unsigned r, input int unsigned l,
                              output int unsigned nr, output int unsigned nl);
        int unsigned n, u, v, rp, lp, d;
        n = ns - 1;
        v = (((r >> 8) * (fh >> 6)) >> 1) + 4 * (n - s);
        if (fl < 32768) begin
            u  = (((r >> 8) * (fl >> 6)) >> 1) + 4 * (n - s + 1);
            lp = l + (r - u);
            rp = u - v;
        end else begin
            lp = l;
            rp = r - v;
        end
        d = 0;
        while (rp < 32768 && d < 16) begin
            rp = rp << 1;
            lp = lp << 1;
            d++;
        end
        nr = rp & 32'hFFFF;
        nl = lp & 32'hFF_FFFF;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge general_clk);
        #1;
        chk("reset_range", 32'(RANGE_OUTPUT), 32'd32768);
        chk("reset_low", 32'(LOW_OUTPUT), 32'd0);
        reset = 1'b0;
        m_rng = 32768;
        m_low = 0;
    endtask

    task automatic send(input string tag, input int unsigned fl, input int unsigned fh,
                        input int unsigned s, input int unsigned ns, input bit scramble);
        int unsigned nr, nl;
        exp_t e;
        general_fl     = 16'(fl);
        general_fh     = 16'(fh);
        general_symbol = 4'(s);
        general_nsyms  = 5'(ns);
        model_step(fl, fh, s, ns, m_rng, m_low, nr, nl);
        sb.push_back('{rng: 16'(nr), low: 24'(nl)});
        @(posedge general_clk);
        #1;
        chk({tag, "_hold_range"}, 32'(RANGE_OUTPUT), m_rng);
        chk({tag, "_hold_low"}, 32'(LOW_OUTPUT), m_low);
        if (scramble) begin
            general_fl     = 16'($urandom);
            general_fh     = 16'($urandom);
            general_symbol = 4'($urandom);
            general_nsyms  = 5'($urandom);
        end
        m_rng = nr;
        m_low = nl;
        @(posedge general_clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_range"}, 32'(RANGE_OUTPUT), 32'(e.rng));
            chk({tag, "_low"}, 32'(LOW_OUTPUT), 32'(e.low));
        end
    endtask

    initial begin
        int unsigned ns, s, fl, fh;
        reset          = 1'b1;
        general_fl     = '0;
        general_fh     = '0;
        general_symbol = '0;
        general_nsyms  = '0;
        m_rng          = 32768;
        m_low          = 0;
        @(posedge general_clk);
        #1;

        apply_reset();
        send("s0_first", 32768, 16384, 0, 2, 1'b0);
        chk("s0_first_known_range", 32'(RANGE_OUTPUT), 32'd65520);
        send("s0_again", 32768, 16384, 0, 2, 1'b0);
        chk("s0_again_known_range", 32'(RANGE_OUTPUT), 32'd32876);

        apply_reset();
        send("s1", 16384, 0, 1, 2, 1'b0);
        chk("s1_known_range", 32'(RANGE_OUTPUT), 32'd32776);
        chk("s1_known_low", 32'(LOW_OUTPUT), 32'd32760);

        send("scramble", 20000, 9000, 2, 5, 1'b1);

        // Reset during the update phase abandons the captured symbol.
        general_fl     = 16'd16384;
        general_fh     = 16'd0;
        general_symbol = 4'd1;
        general_nsyms  = 5'd2;
        @(posedge general_clk);
        #1;
        apply_reset();
        send("post_midreset", 16384, 0, 1, 2, 1'b0);

        apply_reset();
        for (int k = 0; k < 10; k++) begin
            ns = $urandom_range(16, 2);
            s  = $urandom_range(ns - 1, 0);
            if (s == 0) begin
                fl = 32768;
                fh = $urandom_range(32767, 0);
            end else begin
                fl = $urandom_range(32767, 1);
                fh = $urandom_range(fl - 1, 0);
            end
            send($sformatf("stream%0d", k), fl, fh, s, ns, 1'b0);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
